// File: rtl/issue_window.sv
// Four-entry in-order issue window with a 64-bit register scoreboard; ops issue one cycle after enqueue at the earliest.
// Accepts two ops per cycle while count <= 2; offers made while full are dropped and raise a sticky err.
module issue_window (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  in_vld,
   input  logic [72:0] in_data0,
   input  logic [72:0] in_data1,
   output logic        in_rdy,
   input  logic [9:0]  mod_rdy,
   input  logic        wb_vld,
   input  logic [5:0]  wb_reg,
   input  logic        flush,
   output logic        iss_vld,
   output logic [72:0] iss_data,
   output logic [63:0] board,
   output logic        busy,
   output logic        err
);

   typedef struct packed {
      logic [13:0] pc;
      logic [5:0]  ope;
      logic [5:0]  ds;
      logic [5:0]  dt;
      logic [5:0]  dd;
      logic [15:0] imm;
      logic [4:0]  opr;
      logic [3:0]  ctrl;
      logic [9:0]  mod;
   } op_t;

   op_t         mem [4];
   logic [1:0]  head;
   logic [1:0]  tail;
   logic [2:0]  count;

   op_t         hd;
   logic [63:0] need;
   logic        blocked;
   logic        do_iss;
   logic        do_enq;
   logic [1:0]  n_enq;
   logic [63:0] board_nxt;

   // r0 and f0 are hardwired, so they are never tracked on the board
   function automatic logic [63:0] reg_bit(input logic [5:0] r);
      logic [63:0] b;
      b     = 64'd1 << r;
      b[0]  = 1'b0;
      b[32] = 1'b0;
      return b;
   endfunction

   assign hd     = mem[head];
   assign in_rdy = (count <= 3'd2);
   assign busy   = (count != 3'd0);

   always_comb begin
      need      = reg_bit(hd.ds) | reg_bit(hd.dt) | reg_bit(hd.dd);
      blocked   = |(need & board);
      do_iss    = (count != 3'd0) && !blocked && (|(hd.mod & mod_rdy)) && !flush;
      do_enq    = in_rdy && !flush;
      n_enq     = do_enq ? ({1'b0, in_vld[0]} + {1'b0, in_vld[1]}) : 2'd0;
      // clear first so a same-cycle issue of the same register wins
      board_nxt = board;
      if (wb_vld)
         board_nxt = board_nxt & ~reg_bit(wb_reg);
      if (do_iss)
         board_nxt = board_nxt | reg_bit(hd.dd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            mem[i] <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         board    <= '0;
         iss_vld  <= 1'b0;
         iss_data <= '0;
         err      <= 1'b0;
      end else begin
         if ((in_vld != 2'b00) && !in_rdy)
            err <= 1'b1;
         board <= board_nxt;
         if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            iss_vld <= 1'b0;
         end else begin
            if (do_enq) begin
               if (in_vld[0])
                  mem[tail] <= in_data0;
               if (in_vld[1])
                  mem[tail + {1'b0, in_vld[0]}] <= in_data1;
               tail <= tail + n_enq;
            end
            iss_vld <= do_iss;
            if (do_iss) begin
               iss_data <= hd;
               head     <= head + 2'd1;
            end
            count <= count + {1'b0, n_enq} - {2'b00, do_iss};
         end
      end
   end

endmodule

// File: tb/tb_issue_window.sv
// Directed bench for issue_window: hand-computed expectations for issue order, hazards, overflow, flush and r0/f0 masking.
module tb_issue_window;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_vld;
   logic [72:0] in_data0, in_data1;
   logic        in_rdy;
   logic [9:0]  mod_rdy;
   logic        wb_vld;
   logic [5:0]  wb_reg;
   logic        flush;
   logic        iss_vld;
   logic [72:0] iss_data;
   logic [63:0] board;
   logic        busy;
   logic        err;

   int errors = 0;
   int checks = 0;

   issue_window dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data0(in_data0), .in_data1(in_data1),
      .in_rdy(in_rdy), .mod_rdy(mod_rdy), .wb_vld(wb_vld), .wb_reg(wb_reg), .flush(flush),
      .iss_vld(iss_vld), .iss_data(iss_data), .board(board), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [72:0] mk(input logic [13:0] pc, input logic [5:0] ds,
                                      input logic [5:0] dt, input logic [5:0] dd,
                                      input logic [9:0] md);
      return {pc, 6'd0, ds, dt, dd, 16'd0, 5'd0, 4'd0, md};
   endfunction

   task automatic wb(input logic [5:0] r);
      wb_vld = 1'b1;
      wb_reg = r;
      tick();
      wb_vld = 1'b0;
   endtask

   logic [72:0] op_a, op_b, op_c;
   logic [13:0] exp_pc [10];
   int sent, got;

   initial begin
      rst = 1'b1; in_vld = '0; in_data0 = '0; in_data1 = '0;
      mod_rdy = 10'h3FF; wb_vld = 1'b0; wb_reg = '0; flush = 1'b0;
      tick(); tick();
      check("rst_iss_vld", iss_vld, 0);
      check("rst_iss_data", iss_data, 0);
      check("rst_board", board, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_in_rdy", in_rdy, 1);
      rst = 1'b0;
      tick();

      // basic: two independent ALU ops
      op_a = mk(14'h10, 0, 0, 3, 10'h008);
      op_b = mk(14'h11, 0, 0, 4, 10'h008);
      in_vld = 2'b11; in_data0 = op_a; in_data1 = op_b;
      tick();
      in_vld = 2'b00;
      check("basic_lat_vld", iss_vld, 0);
      check("basic_busy", busy, 1);
      tick();
      check("basic_v0", iss_vld, 1);
      check("basic_d0", iss_data, op_a);
      check("basic_board0", board, 64'h8);
      tick();
      check("basic_v1", iss_vld, 1);
      check("basic_d1", iss_data, op_b);
      check("basic_board1", board, 64'h18);
      tick();
      check("basic_idle", iss_vld, 0);
      check("basic_hold", iss_data, op_b);
      check("basic_empty", busy, 0);
      wb(3); wb(4);
      check("basic_wb", board, 0);

      // RAW stall: B reads A's destination
      op_a = mk(14'h20, 0, 0, 5, 10'h008);
      op_b = mk(14'h21, 5, 0, 6, 10'h008);
      in_vld = 2'b11; in_data0 = op_a; in_data1 = op_b;
      tick();
      in_vld = 2'b00;
      tick();
      check("raw_a_iss", iss_data, op_a);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("raw_stall", iss_vld, 0);
      end
      wb_vld = 1'b1; wb_reg = 6'd5;
      tick();
      wb_vld = 1'b0;
      check("raw_no_bypass", iss_vld, 0);
      check("raw_cleared", board, 0);
      tick();
      check("raw_b_vld", iss_vld, 1);
      check("raw_b_data", iss_data, op_b);
      check("raw_board", board, 64'h40);
      wb(6);

      // same-cycle issue set and writeback clear of one register
      op_c = mk(14'h30, 0, 0, 9, 10'h008);
      in_vld = 2'b01; in_data0 = op_c;
      tick();
      in_vld = 2'b00;
      wb_vld = 1'b1; wb_reg = 6'd9;
      tick();
      check("setwin_vld", iss_vld, 1);
      check("setwin_board", board, 64'h200);
      tick();
      wb_vld = 1'b0;
      check("setwin_clear", board, 0);

      // full / overflow with all modules stalled
      mod_rdy = 10'h000;
      in_vld = 2'b11; in_data0 = mk(14'h40, 0, 0, 0, 10'h001); in_data1 = mk(14'h41, 0, 0, 0, 10'h001);
      tick();
      check("full_rdy2", in_rdy, 1);
      in_data0 = mk(14'h42, 0, 0, 0, 10'h001); in_data1 = mk(14'h43, 0, 0, 0, 10'h001);
      tick();
      check("full_rdy4", in_rdy, 0);
      check("full_err0", err, 0);
      in_data0 = mk(14'h44, 0, 0, 0, 10'h001); in_data1 = mk(14'h45, 0, 0, 0, 10'h001);
      tick();
      in_vld = 2'b00;
      check("ovf_err", err, 1);
      mod_rdy = 10'h3FF;
      tick();
      check("drain0", iss_data[72:59], 14'h40);
      check("drain_rdy3", in_rdy, 0);
      tick();
      check("drain1", iss_data[72:59], 14'h41);
      check("drain_rdy2", in_rdy, 1);
      tick();
      check("drain2", iss_data[72:59], 14'h42);
      tick();
      check("drain3", iss_data[72:59], 14'h43);
      tick();
      check("drain_end", iss_vld, 0);
      check("err_sticky", err, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("err_rst", err, 0);

      // wrap-around: 10 ops, mixed 2/1 enqueues, immediate writeback
      for (int i = 0; i < 10; i++) exp_pc[i] = 14'h100 + 14'(i);
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
         in_vld = 2'b00;
         if (in_rdy && sent < 10) begin
            in_data0 = mk(14'h100 + 14'(sent), 0, 0, 6'(sent + 1), 10'h010);
            if ((sent % 3 == 0) && sent < 9) begin
               in_data1 = mk(14'h101 + 14'(sent), 0, 0, 6'(sent + 2), 10'h010);
               in_vld = 2'b11;
               sent += 2;
            end else begin
               in_vld = 2'b01;
               sent += 1;
            end
         end
         wb_vld = iss_vld;
         wb_reg = iss_data[40:35];
         tick();
         if (iss_vld) begin
            check("wrap_order", iss_data[72:59], exp_pc[got]);
            got++;
         end
      end
      in_vld = 2'b00;
      wb_vld = iss_vld;
      wb_reg = iss_data[40:35];
      tick();
      wb_vld = 1'b0;
      check("wrap_count", got, 10);
      check("wrap_board", board, 0);

      // flush with three queued ops and r7 in flight
      in_vld = 2'b01; in_data0 = mk(14'h200, 0, 0, 7, 10'h008);
      tick();
      in_vld = 2'b00;
      tick();
      check("flush_pre_board", board, 64'h80);
      mod_rdy = 10'h000;
      in_vld = 2'b11; in_data0 = mk(14'h201, 0, 0, 0, 10'h008); in_data1 = mk(14'h202, 0, 0, 0, 10'h008);
      tick();
      in_vld = 2'b01; in_data0 = mk(14'h203, 0, 0, 0, 10'h008);
      tick();
      in_vld = 2'b00;
      check("flush_rdy3", in_rdy, 0);
      mod_rdy = 10'h3FF; flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_vld", iss_vld, 0);
      check("flush_busy", busy, 0);
      check("flush_rdy", in_rdy, 1);
      check("flush_board", board, 64'h80);
      tick();
      check("flush_no_iss", iss_vld, 0);
      wb(7);
      check("flush_wb", board, 0);

      // r0/f0 masking: dd=32 neither blocks nor gets tracked
      op_a = mk(14'h300, 0, 32, 32, 10'h100);
      in_vld = 2'b01; in_data0 = op_a;
      tick();
      in_vld = 2'b00;
      tick();
      check("r0_iss", iss_vld, 1);
      check("r0_data", iss_data, op_a);
      check("r0_board", board, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/issue_window.md
# issue_window

Four-entry in-order issue window with a 64-bit register scoreboard. It sits directly downstream of the dual-slot fetch/decode stage and upstream of the execution modules. It accepts up to two 73-bit decoded micro-ops per cycle and holds them until the oldest op's source and destination registers are not busy and its target module is ready. It then issues one op per cycle and tracks destination registers until writeback.

## Interface
- DEPTH, 4: window entries; fixed at 4, count is 3 bits.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  2  per-slot valid; bit 0 = older (even-pc) slot.
- in_data0  in  73  slot-0 decoded op. Field layout:
  - pc[72:59], ope[58:53], ds[52:47], dt[46:41], dd[40:35]
  - imm[34:19], opr[18:14], ctrl[13:10], mod[9:0] (one-hot module select)
- in_data1  in  73  slot-1 decoded op, same layout.
- in_rdy  out  1  window can take two ops this cycle; combinational, count <= 2.
- mod_rdy  in  10  per-module ready, indexed like mod.
- wb_vld  in  1  writeback strobe.
- wb_reg  in  6  writeback register; {fpr/gpr select, index}.
- flush  in  1  discard all queued ops (branch redirect).
- iss_vld  out  1  registered one-cycle issue pulse.
- iss_data  out  73  registered issued op.
- board  out  64  scoreboard, {fpr[63:32], gpr[31:0]}.
- busy  out  1  count != 0.
- err  out  1  sticky overflow flag.

## Operation
- Storage: circular buffer of 4 x 73 bits, with 2-bit head, 2-bit tail and 3-bit count (0..4).
- Enqueue (only when in_rdy=1 and flush=0):
  - slot 0 is written first at tail, then slot 1.
  - If only in_vld[1] is set, slot 1 alone is written at tail.
  - tail advances by popcount(in_vld).
- Overflow:
  - in_vld != 0 while in_rdy=0 sets err.
  - Ops offered in that cycle are dropped.
  - err clears only on rst.
- Hazard mask, evaluated on the head entry:
  - need = (1<<ds) | (1<<dt) | (1<<dd), with bits 0 and 32 forced to 0 (r0/f0 never tracked).
  - Head is blocked if (need & board) != 0.
- Issue condition: count != 0, head not blocked, (mod & mod_rdy) != 0, and flush=0.
- On issue:
  - iss_data <= head entry; iss_vld <= 1.
  - head advances by one.
  - board bit dd is set (unless dd is 0 or 32).
- No issue: iss_vld <= 0 and iss_data holds its value.
- Strict in-order: a blocked head stalls every younger entry.
- Writeback: wb_vld clears board[wb_reg]; wb_reg 0 or 32 is ignored. The cleared bit is visible to the hazard check in the next cycle (no same-cycle bypass).
- Same cycle, same bit: if issue sets a bit and writeback clears it, the set wins.
- Count update: count_next = count + n_enq - n_iss, where n_enq is 0..2 and n_iss is 0..1.
- Enqueue and issue in the same cycle are both legal. An op enqueued this cycle is never issued in that same cycle.
- flush:
  - head, tail and count go to 0; enqueue and issue are suppressed; iss_vld <= 0.
  - board is retained, because in-flight ops still write back.
- rst: all entries 0, head/tail/count 0, board 0, iss_vld 0, iss_data 0, err 0.

## Timing
- Minimum latency: an op enqueued at edge N appears on iss_vld/iss_data after edge N+1.
- Throughput: 1 issue/cycle, 2 enqueues/cycle.
- in_rdy is combinational from count only; it does not depend on the same-cycle issue.
- A dependent op issues no earlier than the cycle after its producer's wb_vld cycle.
- Wrap-around: head and tail wrap modulo 4. Full is count=4 and empty is count=0; neither is inferred from head == tail.
- rst takes priority over flush; flush takes priority over enqueue and issue.

## Test plan
- Basic issue:
  - Stimulus: reset, then enqueue two independent ALU ops (dd=3, dd=4, mod=0x008), mod_rdy=0x3FF.
  - Response: iss_vld high on two consecutive cycles in pc order; board = 0x18.
- RAW stall:
  - Stimulus: op A dd=5, then op B ds=5. No wb until cycle 10, then wb_reg=5.
  - Response: B stays at head until cycle 11 and issues at cycle 12. Bit 5 clears, then re-sets only if B's dd=5.
- Full/overflow:
  - Stimulus: mod_rdy=0; three 2-op bursts.
  - Response: in_rdy drops when count=3. The third burst sets err=1 and count stays at 4 (first two bursts only).
- Wrap-around: 10 back-to-back ops with mixed enqueue and issue, each dd distinct with immediate wb. Required: issue order equals enqueue order across head/tail wrap.
- Flush mid-operation: flush with count=3 and board[7] set. Required: count=0, busy=0, no iss_vld, and board[7] still set until wb_reg=7.
- r0/f0 masking: op with ds=0, dd=32 while board=0. Required: issues immediately and board stays 0.
